// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit_if
// Purpose : Control, instruction-memory and instruction-output bundle for
//           fetch_unit. The master modport is the fetch unit's side. The slave
//           modport is the side of the environment (memory plus consumer).
// Revision: 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
   parameter int n  = 8,
   parameter int AW = 5
);
   logic          start;
   logic          halt_req;
   logic          load_pc;
   logic [AW-1:0] pc_in;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [n-1:0]  mem_q;
   logic [n-1:0]  instr;
   logic [AW-1:0] instr_pc;
   logic          instr_valid;
   logic          instr_ready;
   logic          busy;
   logic          done;

   modport master (
      input  start, halt_req, load_pc, pc_in, mem_q, instr_ready,
      output mem_addr, mem_we, instr, instr_pc, instr_valid, busy, done
   );

   modport slave (
      output start, halt_req, load_pc, pc_in, mem_q, instr_ready,
      input  mem_addr, mem_we, instr, instr_pc, instr_valid, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Purpose : Sequential instruction fetcher. It reads a registered-output
//           instruction memory, tags each returning word with its PC and
//           buffers the pairs in a 2-entry FIFO. The control FSM has three
//           states: IDLE, RUN and DRAIN.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter int n  = 8,
   parameter int AW = 5
) (
   input  logic          clock,
   input  logic          resetn,
   fetch_unit_if.master  bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        r_state;
   logic          r_busy;
   logic          r_done;
   logic [AW-1:0] r_pc;
   logic [AW-1:0] r_tag;
   logic          r_inflight;
   logic [1:0]    r_count;
   logic          r_head_valid;
   logic [n-1:0]  r_head_instr;
   logic [AW-1:0] r_head_pc;
   logic [n-1:0]  r_tail_instr;
   logic [AW-1:0] r_tail_pc;

   logic          w_pop;
   logic          w_halt;
   logic          w_flush;
   logic          w_push;
   logic          w_issue;
   logic          w_drained;
   logic [2:0]    w_occupancy;

   // A halt in RUN takes priority over a redirect. A redirect is ignored in DRAIN.
   assign w_pop       = r_head_valid & bus.instr_ready;
   assign w_halt      = (r_state == RUN) & bus.halt_req;
   assign w_flush     = bus.load_pc & (r_state != DRAIN) & ~w_halt;
   assign w_push      = r_inflight & ~w_flush;
   assign w_occupancy = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_inflight};
   assign w_issue     = (r_state == RUN) & ~bus.load_pc & ~bus.halt_req
                        & (w_occupancy < 3'd2);
   assign w_drained   = (r_count == 2'd0) & ~r_inflight;

   assign bus.mem_addr    = r_pc;
   assign bus.mem_we      = 1'b0;
   assign bus.instr       = r_head_instr;
   assign bus.instr_pc    = r_head_pc;
   assign bus.instr_valid = r_head_valid;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;

   // Control FSM; busy and done are registered alongside the state.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (bus.start) begin
               r_state <= RUN;
               r_busy  <= 1'b1;
            end
            RUN: if (bus.halt_req) begin
               r_state <= DRAIN;
            end
            DRAIN: if (w_drained) begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // PC, tag and in-flight tracking. A flush also kills the returning word.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_pc       <= '0;
         r_tag      <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_flush) begin
            r_pc <= bus.pc_in;
         end else if (w_issue) begin
            r_tag <= r_pc;
            r_pc  <= r_pc + AW'(1);
         end
      end
   end

   // 2-entry FIFO. The head stays in registers that drive the outputs, and it
   // keeps its last value when the FIFO empties.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_count      <= 2'd0;
         r_head_valid <= 1'b0;
         r_head_instr <= '0;
         r_head_pc    <= '0;
         r_tail_instr <= '0;
         r_tail_pc    <= '0;
      end else if (w_flush) begin
         r_count      <= 2'd0;
         r_head_valid <= 1'b0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_head_instr <= bus.mem_q;
                  r_head_pc    <= r_tag;
                  r_head_valid <= 1'b1;
               end else begin
                  r_tail_instr <= bus.mem_q;
                  r_tail_pc    <= r_tag;
               end
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               if (r_count == 2'd2) begin
                  r_head_instr <= r_tail_instr;
                  r_head_pc    <= r_tail_pc;
               end else begin
                  r_head_valid <= 1'b0;
               end
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd2) begin
                  r_head_instr <= r_tail_instr;
                  r_head_pc    <= r_tail_pc;
                  r_tail_instr <= bus.mem_q;
                  r_tail_pc    <= r_tag;
               end else begin
                  r_head_instr <= bus.mem_q;
                  r_head_pc    <= r_tag;
               end
            end
            default: ;
         endcase
      end
   end

   // The issue throttle must make a push into a full, non-popping FIFO impossible.
   a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
      !(w_push && !w_pop && (r_count == 2'd2)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_unit
// Purpose : Directed bench for fetch_unit. It uses a registered-read
//           instruction memory and hand-derived expected cycle timing.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
   logic clock = 1'b0;
   logic resetn;
   int   n_checks = 0;
   int   n_pass   = 0;

   fetch_unit_if #(.n(8), .AW(5)) bus ();

   fetch_unit #(.n(8), .AW(5)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   // Words 0..3 are fixed. Every other word i holds 8'h40 | i.
   function automatic logic [7:0] exp_word(input logic [4:0] a);
      case (a)
         5'd0:    return 8'h80;
         5'd1:    return 8'h3E;
         5'd2:    return 8'h80;
         5'd3:    return 8'h3F;
         default: return {3'b010, a};
      endcase
   endfunction

   logic [7:0] mem [32];
   initial for (int i = 0; i < 32; i++) mem[i] = exp_word(5'(i));

   // Registered-read instruction memory.
   always @(posedge clock) bus.mem_q <= mem[bus.mem_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   // Expect num consecutive valid instructions from pc0 onward, one per cycle.
   task automatic stream(input string tag, input logic [4:0] pc0, input int num);
      logic [4:0] p;
      for (int i = 0; i < num; i++) begin
         p = pc0 + 5'(i);
         check($sformatf("%s_valid%0d", tag, i), bus.instr_valid, 1);
         check($sformatf("%s_pc%0d", tag, i), bus.instr_pc, p);
         check($sformatf("%s_instr%0d", tag, i), bus.instr, exp_word(p));
         tick();
      end
   endtask

   task automatic wait_done(input string tag);
      bit seen = 0;
      for (int i = 0; i < 12 && !seen; i++) begin
         if (bus.done) seen = 1;
         else tick();
      end
      check({tag, "_done_seen"}, seen, 1);
      if (seen) begin
         check({tag, "_busy_low"}, bus.busy, 0);
         tick();
         check({tag, "_done_once"}, bus.done, 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      resetn          = 1'b0;
      bus.start       = 1'b0;
      bus.halt_req    = 1'b0;
      bus.load_pc     = 1'b0;
      bus.pc_in       = 5'd0;
      bus.instr_ready = 1'b0;
      tick();
      check("rst_valid", bus.instr_valid, 0);
      check("rst_instr", bus.instr, 0);
      check("rst_ipc", bus.instr_pc, 0);
      check("rst_addr", bus.mem_addr, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_we", bus.mem_we, 0);
      resetn = 1'b1;
      tick();

      // Basic fetch latency and throughput.
      bus.start = 1'b1; bus.instr_ready = 1'b1;
      tick();
      bus.start = 1'b0;
      check("lat_busy", bus.busy, 1);
      check("lat_v0", bus.instr_valid, 0);
      tick();
      check("lat_v1", bus.instr_valid, 0);
      tick();
      stream("seq", 5'd0, 6);
      check("seq_head6", bus.instr_pc, 6);

      // Halt and redirect in the same cycle: the halt wins.
      bus.halt_req = 1'b1; bus.load_pc = 1'b1; bus.pc_in = 5'd5;
      tick();
      bus.halt_req = 1'b0; bus.load_pc = 1'b0;
      check("hl_v7", bus.instr_valid, 1);
      check("hl_pc7", bus.instr_pc, 7);
      check("hl_i7", bus.instr, 8'h47);
      check("hl_busy", bus.busy, 1);
      tick();
      check("hl_empty", bus.instr_valid, 0);
      check("hl_hold_pc", bus.instr_pc, 7);
      check("hl_nodone", bus.done, 0);
      tick();
      check("hl_done", bus.done, 1);
      check("hl_busy0", bus.busy, 0);
      check("hl_addr", bus.mem_addr, 8);
      tick();
      check("hl_done_once", bus.done, 0);

      // Back-pressure with a full buffer, then release.
      bus.load_pc = 1'b1; bus.pc_in = 5'd0;
      tick();
      bus.load_pc = 1'b0;
      check("bp_addr0", bus.mem_addr, 0);
      bus.start = 1'b1; bus.instr_ready = 1'b0;
      tick();
      bus.start = 1'b0;
      repeat (10) tick();
      check("bp_addr2", bus.mem_addr, 2);
      check("bp_valid", bus.instr_valid, 1);
      check("bp_head", bus.instr_pc, 0);
      bus.instr_ready = 1'b1;
      stream("bp", 5'd0, 5);

      // Redirect while two entries are buffered.
      bus.instr_ready = 1'b0;
      repeat (3) tick();
      check("rd_head5", bus.instr_pc, 5);
      check("rd_addr7", bus.mem_addr, 7);
      bus.load_pc = 1'b1; bus.pc_in = 5'd8; bus.instr_ready = 1'b1;
      tick();
      bus.load_pc = 1'b0;
      check("rd_flush", bus.instr_valid, 0);
      check("rd_addr8", bus.mem_addr, 8);
      tick();
      check("rd_gap", bus.instr_valid, 0);
      tick();
      stream("rd", 5'd8, 3);

      // Redirect with a fetch in flight: the returning word must be dropped.
      bus.load_pc = 1'b1; bus.pc_in = 5'd20;
      tick();
      bus.load_pc = 1'b0;
      check("st_flush", bus.instr_valid, 0);
      tick();
      check("st_drop", bus.instr_valid, 0);
      tick();
      stream("st", 5'd20, 3);
      bus.halt_req = 1'b1;
      tick();
      bus.halt_req = 1'b0;
      wait_done("st");

      // Wrap-around of the PC.
      bus.load_pc = 1'b1; bus.pc_in = 5'd30;
      tick();
      bus.load_pc = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      stream("wr", 5'd30, 4);

      // Asynchronous reset with a full buffer.
      bus.instr_ready = 1'b0;
      repeat (3) tick();
      check("ar_pre_v", bus.instr_valid, 1);
      check("ar_pre_addr", bus.mem_addr, 4);
      #2 resetn = 1'b0;
      #1;
      check("ar_valid", bus.instr_valid, 0);
      check("ar_addr", bus.mem_addr, 0);
      check("ar_ipc", bus.instr_pc, 0);
      check("ar_busy", bus.busy, 0);
      tick();
      resetn = 1'b1; bus.instr_ready = 1'b1;
      tick();
      tick();
      check("ar_idle", bus.busy, 0);
      check("ar_idle_v", bus.instr_valid, 0);
      check("ar_idle_addr", bus.mem_addr, 0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      stream("ar", 5'd0, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: n, default 8, instruction width in bits; SHALL match the data width of the instruction memory.
REQ-002 Parameter: AW, default 5, address and PC width in bits (32-word memory).
REQ-003 clock  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  in IDLE: begin fetching from the current PC.
REQ-006 halt_req  input  1  in RUN: stop issuing and drain.
REQ-007 load_pc  input  1  redirect the PC to pc_in.
REQ-008 pc_in  input  AW  new PC value, used when load_pc=1.
REQ-009 mem_addr  output  AW  read address to instruction memory; SHALL equal the PC register.
REQ-010 mem_we  output  1  memory write enable; SHALL be constant 0.
REQ-011 mem_q  input  n  memory read data; registered in memory, so it holds word[mem_addr] sampled at the previous edge.
REQ-012 instr  output  n  instruction at the head of the buffer.
REQ-013 instr_pc  output  AW  address the head instruction was fetched from.
REQ-014 instr_valid  output  1  buffer head holds valid data.
REQ-015 instr_ready  input  1  consumer accepts; pop occurs when instr_valid=1 and instr_ready=1.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 done  output  1  one-cycle pulse on the DRAIN->IDLE transition.

Function
REQ-018 FSM states SHALL be IDLE, RUN and DRAIN.
- IDLE->RUN on start=1.
- RUN->DRAIN on halt_req=1.
- DRAIN->IDLE when the buffer is empty and no fetch is in flight.
REQ-019 The buffer SHALL be a 2-entry FIFO of {instr, pc}; its head drives instr, instr_pc and instr_valid directly from registers.
REQ-020 Issue condition: state=RUN, load_pc=0, halt_req=0, and (count - pop + inflight) < 2, where count, pop and inflight are as follows.
- count: current buffer occupancy.
- pop: 1 if a pop occurs this cycle.
- inflight: 1 if a fetch was issued in the previous cycle.
REQ-021 On issue, at the same edge:
- inflight set to 1;
- the tag register captures PC;
- PC becomes (PC+1) mod 2^AW, so 31 wraps to 0.
REQ-022 With no issue, inflight SHALL clear to 0 at the next edge and PC SHALL hold.
REQ-023 When inflight=1, mem_q SHALL be pushed into the buffer with the tag at the next edge.
- Latency: PC issued at edge E; the instruction is visible on instr_valid/instr after edge E+1.
REQ-024 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
- Push into a full buffer is impossible by REQ-020; an assertion SHALL check it.
REQ-025 With instr_ready held at 1 in RUN, sustained throughput SHALL be one instruction per cycle.
REQ-026 load_pc=1 in IDLE or RUN SHALL take effect at the next edge:
- PC set to pc_in;
- buffer flushed (count=0);
- inflight cleared, so the returning mem_q is discarded;
- no issue in that cycle.
REQ-027 load_pc SHALL be ignored in DRAIN.
REQ-028 halt_req together with load_pc in RUN: halt wins and load_pc is ignored.
REQ-029 start SHALL be ignored outside IDLE; halt_req SHALL be ignored outside RUN.
REQ-030 In DRAIN, buffered and in-flight instructions SHALL still be delivered normally.
REQ-031 If DRAIN is entered with an empty buffer and no fetch in flight, the FSM SHALL return to IDLE at the next edge with done=1 for exactly that following cycle.
REQ-032 Buffer entries are not observable while instr_valid=0; instr and instr_pc SHALL hold their last values.

Reset
REQ-033 resetn=0 SHALL immediately, without waiting for a clock edge, force the following:
- state=IDLE, PC=0 (mem_addr=0);
- count=0, inflight=0, tag=0;
- instr_valid=0, instr=0, instr_pc=0;
- busy=0, done=0.
REQ-034 Reset asserted mid-fetch SHALL discard all buffered and in-flight data; after release the block SHALL wait for start.

Verification
REQ-035 Memory model: registered read, word0=8'h80, word1=8'h3E, word2=8'h80, word3=8'h3F; reset then start at edge E0 with instr_ready=1 -> instr_valid first high after E2 with instr=8'h80, instr_pc=0, then 8'h3E/1, 8'h80/2, 8'h3F/3 on consecutive cycles.
REQ-036 start, then instr_ready=0 for 10 cycles -> count=2 and PC stops at 2 (only 0 and 1 issued); then instr_ready=1 -> addresses 0, 1, 2, ... delivered with no gap and no duplicate.
REQ-037 load_pc=1 with pc_in=30 in IDLE, then start -> instr_pc sequence 30, 31, 0, 1 (wrap-around).
REQ-038 In RUN with 2 entries buffered, load_pc=1 with pc_in=8 -> instr_valid=0 next cycle, the stale in-flight word is dropped, and the next delivered instr_pc is 8.
REQ-039 halt_req=1 and load_pc=1 in the same RUN cycle with instr_ready=1 -> no new issue, remaining entries delivered, done pulses once, busy falls with it, PC unchanged by pc_in.
REQ-040 resetn=0 asynchronously while count=2 -> instr_valid=0 and mem_addr=0 before the next edge; after release start re-fetches from address 0.
